mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single data-memory/IO load-store unit between two requesters.
  - Port P: the pipeline memory stage.
  - Port D: the debug/program-loader master.
- Issues at most one access per cycle.
- Pipeline has priority. A saturating wait counter guarantees the debug master forward progress, and a lock mode gives the debug master back-to-back exclusive bursts.
- Routes the one-cycle-late read data back to whichever port issued the load.

Parameters:
- MAX_WAIT, 4: cycles the debug port may be denied while P requests before D is forced through (≥1).
- WAIT_W, $clog2(MAX_WAIT+1): width of the wait counter.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_p_req  in  1  pipeline access request (load or store in M stage)
- i_p_wren  in  1  pipeline store enable
- i_p_funct3  in  3  pipeline access size/sign (RISC-V funct3)
- i_p_addr  in  32  pipeline address
- i_p_wdata  in  32  pipeline store data
- o_p_stall  out  1  pipeline must hold M stage and M/W register this cycle
- o_p_rvalid  out  1  pipeline load data valid
- o_p_rdata  out  32  pipeline load data
- i_d_req  in  1  debug request; fields held stable until granted
- i_d_lock  in  1  debug requests exclusive ownership after the next grant
- i_d_wren  in  1  debug store enable
- i_d_funct3  in  3  debug access size
- i_d_addr  in  32  debug address
- i_d_wdata  in  32  debug store data
- o_d_gnt  out  1  debug access issued this cycle
- o_d_rvalid  out  1  debug load data valid
- o_d_rdata  out  32  debug load data
- o_lsu_wren  out  1  to LSU store enable
- o_lsu_funct3  out  3  to LSU
- o_lsu_addr  out  32  to LSU
- o_lsu_wdata  out  32  to LSU
- i_lsu_rdata  in  32  LSU load data; valid the cycle after the address is presented

Behaviour:
- Reset (async, i_rst_n=0):
  - State = ARB, wait_cnt = 0, rsp_owner = NONE.
  - All outputs are 0: o_p_stall, o_d_gnt, both rvalids, both rdatas, o_lsu_*.
  - A load pending at reset has its response dropped; no rvalid after release.
- FSM states:
  - ARB: normal arbitration.
  - LOCKED: debug owns the LSU.
- Grant rule in ARB, decided combinationally each cycle:
  - sel_d = i_d_req && (!i_p_req || wait_cnt==MAX_WAIT).
  - sel_p = i_p_req && !sel_d.
- Grant rule in LOCKED:
  - sel_d = i_d_req.
  - sel_p = 0.
  - o_p_stall = i_p_req.
- LSU mux:
  - sel_d drives the D fields, sel_p drives the P fields.
  - With neither selected: o_lsu_wren=0; addr/wdata/funct3 hold P values (don't-care, no write).
- Outputs:
  - o_d_gnt = sel_d.
  - o_p_stall = i_p_req && !sel_p.
- Wait counter (ARB only):
  - Increments when i_d_req && !sel_d, saturating at MAX_WAIT.
  - Clears to 0 on sel_d or !i_d_req.
  - Held at 0 in LOCKED.
- Transitions:
  - ARB→LOCKED on sel_d && i_d_lock.
  - LOCKED→ARB on the first cycle with !i_d_lock; that cycle is already arbitrated as ARB (combinational exit).
  - In LOCKED, i_d_req=0 with i_d_lock=1 keeps the lock: LSU idle, P stalled.
- Response path, registered:
  - rsp_owner <= P if sel_p && !i_p_wren; D if sel_d && !i_d_wren; else NONE.
  - Next cycle: o_x_rvalid=1 for the owner, o_x_rdata=i_lsu_rdata.
  - Non-owner rdata = 0.
  - Stores produce no rvalid.
- Latency:
  - Grant to LSU: 0 cycles.
  - Load data: 1 cycle after grant.
  - Full throughput: one access per cycle, back-to-back allowed, alternating owners allowed.
- Simultaneous events:
  - P and D requesting with wait_cnt<MAX_WAIT: P wins.
  - At MAX_WAIT: D wins once, then the counter clears.
  - Exactly one grant per cycle maximum; never both.

Decomposition:
- Package mem_arb_pkg:
  - state enum {ARB, LOCKED}.
  - owner enum {OWN_NONE, OWN_P, OWN_D}.
  - funct3 constants LB/LH/LW/LBU/LHU/SB/SH/SW.
- One sub-module: arb_wait_counter (saturating counter with inc/clr, parameter MAX_WAIT, output at_max).

Test Plan:
- Reset mid-load: P load to 0x0000_2000 granted, i_rst_n pulsed low next cycle -> o_p_rvalid stays 0, all outputs 0, state ARB.
- P only: back-to-back loads 0x100, 0x104 with LSU returning 0xDEAD_BEEF, 0x1234_5678 -> o_p_rvalid=1 on cycles N+1, N+2 with those values; o_p_stall=0 throughout.
- Starvation (MAX_WAIT=4): P and D both request continuously -> P granted 4 cycles with D wait_cnt 1..4, D granted on cycle 5 (o_p_stall=1 that cycle), P resumes cycle 6.
- D alone: D store 0xA5 (SB) to 0x7000 -> o_d_gnt=1 same cycle, o_lsu_wren=1, no rvalid on either port.
- Lock burst: D holds i_d_lock with 3 loads while P requests -> o_p_stall=1 for all 3 plus any idle locked cycles; o_d_rvalid on each following cycle; P granted on the cycle i_d_lock drops.
- Mixed owners: P load granted cycle N, D load granted cycle N+1 -> o_p_rvalid at N+1 only, o_d_rvalid at N+2 only, rdata routed correctly.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Covers the arbitration state, the load-response owner and the RISC-V access sizes.
package mem_arb_pkg;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Only an issued load earns a response slot.
  function automatic owner_e load_owner(input logic sel_p, input logic p_wren,
                                        input logic sel_d, input logic d_wren);
    owner_e own;
    own = OWN_NONE;
    if (sel_d && !d_wren) begin
      own = OWN_D;
    end else if (sel_p && !p_wren) begin
      own = OWN_P;
    end else begin
      own = OWN_NONE;
    end
    return own;
  endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating count of cycles the debug port has been denied.
// Clear dominates increment; at_max flags the forced-grant threshold.
module arb_wait_counter #(
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = $clog2(MAX_WAIT + 1)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  logic [WAIT_W-1:0] count_r;

  assign at_max = (count_r == WAIT_W'(MAX_WAIT));

  // Counter register, holds at MAX_WAIT until cleared.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (inc && !at_max) begin
      count_r <= count_r + {{(WAIT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the load-store unit between the pipeline (priority) and the debug master.
// Grants are combinational; load data is routed back one cycle later to its issuer.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = $clog2(MAX_WAIT + 1)
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_p_req,
  input  logic        i_p_wren,
  input  logic [2:0]  i_p_funct3,
  input  logic [31:0] i_p_addr,
  input  logic [31:0] i_p_wdata,
  output logic        o_p_stall,
  output logic        o_p_rvalid,
  output logic [31:0] o_p_rdata,
  input  logic        i_d_req,
  input  logic        i_d_lock,
  input  logic        i_d_wren,
  input  logic [2:0]  i_d_funct3,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  output logic        o_d_gnt,
  output logic        o_d_rvalid,
  output logic [31:0] o_d_rdata,
  output logic        o_lsu_wren,
  output logic [2:0]  o_lsu_funct3,
  output logic [31:0] o_lsu_addr,
  output logic [31:0] o_lsu_wdata,
  input  logic [31:0] i_lsu_rdata
);

  arb_state_e state_r, state_next_s;
  owner_e     owner_r;
  logic       sel_p_s, sel_d_s;
  logic       cnt_inc_s, cnt_clr_s, at_max_s;

  arb_wait_counter #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) u_wait_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .inc     (cnt_inc_s),
    .clr     (cnt_clr_s),
    .at_max  (at_max_s)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ARB;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Grant decision; dropping the lock is arbitrated normally in the same cycle.
  always_comb begin
    sel_d_s      = 1'b0;
    sel_p_s      = 1'b0;
    cnt_inc_s    = 1'b0;
    cnt_clr_s    = 1'b1;
    state_next_s = state_r;
    case (state_r)
      LOCKED: begin
        if (i_d_lock) begin
          sel_d_s      = i_d_req;
          sel_p_s      = 1'b0;
          state_next_s = LOCKED;
        end else begin
          sel_d_s      = i_d_req && !i_p_req;
          sel_p_s      = i_p_req && !sel_d_s;
          cnt_inc_s    = i_d_req && !sel_d_s;
          cnt_clr_s    = !cnt_inc_s;
          state_next_s = ARB;
        end
      end
      default: begin
        sel_d_s      = i_d_req && (!i_p_req || at_max_s);
        sel_p_s      = i_p_req && !sel_d_s;
        cnt_inc_s    = i_d_req && !sel_d_s;
        cnt_clr_s    = !cnt_inc_s;
        state_next_s = (sel_d_s && i_d_lock) ? LOCKED : ARB;
      end
    endcase
  end

  // LSU mux and handshakes; everything reads zero while reset is asserted.
  always_comb begin
    o_d_gnt      = 1'b0;
    o_p_stall    = 1'b0;
    o_lsu_wren   = 1'b0;
    o_lsu_funct3 = 3'b000;
    o_lsu_addr   = 32'h0000_0000;
    o_lsu_wdata  = 32'h0000_0000;
    if (!i_rst_n) begin
      o_d_gnt = 1'b0;
    end else if (sel_d_s) begin
      o_d_gnt      = 1'b1;
      o_p_stall    = i_p_req;
      o_lsu_wren   = i_d_wren;
      o_lsu_funct3 = i_d_funct3;
      o_lsu_addr   = i_d_addr;
      o_lsu_wdata  = i_d_wdata;
    end else begin
      o_p_stall    = i_p_req && !sel_p_s;
      o_lsu_wren   = sel_p_s && i_p_wren;
      o_lsu_funct3 = i_p_funct3;
      o_lsu_addr   = i_p_addr;
      o_lsu_wdata  = i_p_wdata;
    end
  end

  // Remember who issued this cycle's load so next cycle's data goes to them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      owner_r <= OWN_NONE;
    end else begin
      owner_r <= load_owner(sel_p_s, i_p_wren, sel_d_s, i_d_wren);
    end
  end

  assign o_p_rvalid = (owner_r == OWN_P);
  assign o_d_rvalid = (owner_r == OWN_D);
  assign o_p_rdata  = o_p_rvalid ? i_lsu_rdata : 32'h0000_0000;
  assign o_d_rdata  = o_d_rvalid ? i_lsu_rdata : 32'h0000_0000;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter: per-cycle grant model plus a load-response
// scoreboard drained by an independent monitor.
module tb_mem_port_arbiter;

  localparam int MAX_WAIT = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_p_req = 1'b0, i_p_wren = 1'b0;
  logic [2:0]  i_p_funct3 = 3'b000;
  logic [31:0] i_p_addr = 32'h0, i_p_wdata = 32'h0;
  logic        i_d_req = 1'b0, i_d_lock = 1'b0, i_d_wren = 1'b0;
  logic [2:0]  i_d_funct3 = 3'b000;
  logic [31:0] i_d_addr = 32'h0, i_d_wdata = 32'h0;
  logic [31:0] i_lsu_rdata = 32'h0;
  logic        o_p_stall, o_p_rvalid, o_d_gnt, o_d_rvalid, o_lsu_wren;
  logic [31:0] o_p_rdata, o_d_rdata, o_lsu_addr, o_lsu_wdata;
  logic [2:0]  o_lsu_funct3;

  mem_port_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_p_req(i_p_req), .i_p_wren(i_p_wren), .i_p_funct3(i_p_funct3),
    .i_p_addr(i_p_addr), .i_p_wdata(i_p_wdata),
    .o_p_stall(o_p_stall), .o_p_rvalid(o_p_rvalid), .o_p_rdata(o_p_rdata),
    .i_d_req(i_d_req), .i_d_lock(i_d_lock), .i_d_wren(i_d_wren), .i_d_funct3(i_d_funct3),
    .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata),
    .o_d_gnt(o_d_gnt), .o_d_rvalid(o_d_rvalid), .o_d_rdata(o_d_rdata),
    .o_lsu_wren(o_lsu_wren), .o_lsu_funct3(o_lsu_funct3),
    .o_lsu_addr(o_lsu_addr), .o_lsu_wdata(o_lsu_wdata),
    .i_lsu_rdata(i_lsu_rdata)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int          port;   // 1 = pipeline, 2 = debug
    logic [31:0] data;
    int          cyc;
  } rsp_t;

  rsp_t q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;

  // Reference state: debug denial streak, lock ownership, pending load issuer.
  int   m_streak = 0;
  bit   m_locked = 1'b0;
  int   m_pend = 0;
  bit   m_gd = 1'b0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end else begin
      passes++;
    end
  endfunction

  task automatic step(input bit rst,
                      input bit preq, input bit pw, input logic [2:0] pf3,
                      input logic [31:0] pa, input logic [31:0] pwd,
                      input bit dreq, input bit dlock, input bit dw, input logic [2:0] df3,
                      input logic [31:0] da, input logic [31:0] dwd,
                      input logic [31:0] rd);
    bit leff, gd, gp;
    @(negedge i_clk);
    cyc++;
    i_rst_n = !rst;
    i_p_req = preq; i_p_wren = pw; i_p_funct3 = pf3; i_p_addr = pa; i_p_wdata = pwd;
    i_d_req = dreq; i_d_lock = dlock; i_d_wren = dw; i_d_funct3 = df3;
    i_d_addr = da; i_d_wdata = dwd;
    i_lsu_rdata = rd;
    if (rst) begin
      q.delete();
      m_streak = 0; m_locked = 1'b0; m_pend = 0; m_gd = 1'b0;
      #1;
      chk("rst_ctrl", {o_p_stall, o_d_gnt, o_p_rvalid, o_d_rvalid, o_lsu_wren, o_lsu_funct3}, 64'd0);
      chk("rst_addr_wdata", {o_lsu_addr, o_lsu_wdata}, 64'd0);
      chk("rst_rdata", {o_p_rdata, o_d_rdata}, 64'd0);
    end else begin
      if (m_pend != 0) q.push_back('{port: m_pend, data: rd, cyc: cyc});
      leff = m_locked && dlock;
      if (leff) begin
        gd = dreq;
        gp = 1'b0;
      end else begin
        gd = dreq && (!preq || m_streak >= MAX_WAIT);
        gp = preq && !gd;
      end
      #1;
      chk("d_gnt", {63'd0, o_d_gnt}, {63'd0, gd});
      chk("p_stall", {63'd0, o_p_stall}, {63'd0, (preq && !gp)});
      if (gd) begin
        chk("lsu_d", {o_lsu_wren, o_lsu_funct3, o_lsu_addr}, {28'd0, dw, df3, da});
        chk("lsu_d_wdata", {32'd0, o_lsu_wdata}, {32'd0, dwd});
      end else begin
        chk("lsu_p", {o_lsu_wren, o_lsu_funct3, o_lsu_addr}, {28'd0, (gp && pw), pf3, pa});
        chk("lsu_p_wdata", {32'd0, o_lsu_wdata}, {32'd0, pwd});
      end
      if (leff) m_streak = 0;
      else if (dreq && !gd) m_streak = (m_streak + 1 > MAX_WAIT) ? MAX_WAIT : m_streak + 1;
      else m_streak = 0;
      m_locked = leff ? 1'b1 : (gd && dlock);
      m_pend = (gd && !dw) ? 2 : ((gp && !pw) ? 1 : 0);
      m_gd = gd;
    end
  endtask

  // Monitor: every DUT response must match the oldest expected one, in the right cycle.
  always begin
    @(negedge i_clk);
    #2;
    if (q.size() > 0 && q[0].cyc < cyc) begin
      chk("rsp_missing", 64'(q[0].cyc), 64'(cyc));
      void'(q.pop_front());
    end
    if (o_p_rvalid && o_d_rvalid) begin
      chk("rvalid_both", 64'd1, 64'd0);
    end else if (o_p_rvalid || o_d_rvalid) begin
      if (q.size() == 0) begin
        chk("rvalid_unexpected", {62'd0, o_d_rvalid, o_p_rvalid}, 64'd0);
      end else begin
        rsp_t e;
        e = q.pop_front();
        chk("rsp_port", o_p_rvalid ? 64'd1 : 64'd2, 64'(e.port));
        chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
        chk("rsp_data", {32'd0, (o_p_rvalid ? o_p_rdata : o_d_rdata)}, {32'd0, e.data});
        chk("rsp_other_zero", {32'd0, (o_p_rvalid ? o_d_rdata : o_p_rdata)}, 64'd0);
      end
    end else begin
      chk("rdata_idle_zero", {o_p_rdata, o_d_rdata}, 64'd0);
    end
  end

  initial begin
    bit dreq_r = 1'b0, dlock_r = 1'b0, dw_r = 1'b0;
    logic [2:0]  df3_r = 3'b000;
    logic [31:0] da_r = 32'h0, dwd_r = 32'h0;
    // Reset and reset during an outstanding load.
    step(1, 1,0,3'b010,32'h1111_0000,32'h0, 1,0,0,3'b010,32'h2222_0000,32'h0, 32'h0);
    step(1, 0,0,3'b000,32'h0,32'h0, 0,0,0,3'b000,32'h0,32'h0, 32'h0);
    step(0, 1,0,3'b010,32'h0000_2000,32'h0, 0,0,0,3'b000,32'h0,32'h0, 32'h0);
    step(1, 1,0,3'b010,32'h0000_2004,32'h0, 0,0,0,3'b000,32'h0,32'h0, 32'hCAFE_0001);
    step(0, 0,0,3'b000,32'h0,32'h0, 0,0,0,3'b000,32'h0,32'h0, 32'hCAFE_0002);
    step(0, 0,0,3'b000,32'h0,32'h0, 0,0,0,3'b000,32'h0,32'h0, 32'hCAFE_0003);
    // Pipeline back-to-back loads.
    step(0, 1,0,3'b010,32'h0000_0100,32'h0, 0,0,0,3'b000,32'h0,32'h0, 32'h0);
    step(0, 1,0,3'b010,32'h0000_0104,32'h0, 0,0,0,3'b000,32'h0,32'h0, 32'hDEAD_BEEF);
    step(0, 0,0,3'b000,32'h0,32'h0, 0,0,0,3'b000,32'h0,32'h0, 32'h1234_5678);
    // Starvation: both request continuously.
    for (int i = 0; i < 7; i++)
      step(0, 1,0,3'b010,32'h0000_0200 + 32'(4*i),32'h0, 1,0,0,3'b010,32'h0000_0300,32'h0, 32'h5000_0000 + 32'(i));
    // Debug byte store alone.
    step(0, 0,0,3'b000,32'h0,32'h0, 1,0,1,3'b000,32'h0000_7000,32'h0000_00A5, 32'h0);
    step(0, 0,0,3'b000,32'h0,32'h0, 0,0,0,3'b000,32'h0,32'h0, 32'h0BAD_0BAD);
    // Lock burst while the pipeline keeps requesting.
    for (int i = 0; i < 5; i++)
      step(0, 1,0,3'b010,32'h0000_0400,32'h0, 1,1,0,3'b010,32'h0000_0500,32'h0, 32'h6000_0000 + 32'(i));
    step(0, 1,0,3'b010,32'h0000_0400,32'h0, 1,1,0,3'b010,32'h0000_0504,32'h0, 32'h6100_0000);
    step(0, 1,0,3'b010,32'h0000_0400,32'h0, 1,1,0,3'b010,32'h0000_0508,32'h0, 32'h6200_0000);
    step(0, 1,0,3'b010,32'h0000_0400,32'h0, 0,1,0,3'b000,32'h0,32'h0, 32'h6300_0000);
    step(0, 1,0,3'b010,32'h0000_0400,32'h0, 0,0,0,3'b000,32'h0,32'h0, 32'h6400_0000);
    // Mixed owners on consecutive cycles.
    step(0, 1,0,3'b010,32'h0000_0800,32'h0, 0,0,0,3'b000,32'h0,32'h0, 32'h6500_0000);
    step(0, 0,0,3'b000,32'h0,32'h0, 1,0,0,3'b010,32'h0000_0900,32'h0, 32'hAAAA_0001);
    step(0, 0,0,3'b000,32'h0,32'h0, 0,0,0,3'b000,32'h0,32'h0, 32'hBBBB_0002);
    step(0, 0,0,3'b000,32'h0,32'h0, 0,0,0,3'b000,32'h0,32'h0, 32'hCCCC_0003);
    // Random traffic; debug fields stay stable until granted.
    for (int i = 0; i < 3000; i++) begin
      if (!dreq_r || m_gd) begin
        dreq_r = ($urandom_range(0, 99) < 45);
        dw_r   = $urandom_range(0, 1) == 1;
        df3_r  = 3'($urandom_range(0, 7));
        da_r   = $urandom;
        dwd_r  = $urandom;
        if ($urandom_range(0, 99) < 20) dlock_r = !dlock_r;
      end
      step(($urandom_range(0, 999) == 0),
           ($urandom_range(0, 99) < 70), ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)),
           $urandom, $urandom,
           dreq_r, dlock_r, dw_r, df3_r, da_r, dwd_r, $urandom);
    end
    for (int i = 0; i < 3; i++)
      step(0, 0,0,3'b000,32'h0,32'h0, 0,0,0,3'b000,32'h0,32'h0, 32'h0);
    @(negedge i_clk);
    #3;
    chk("rsp_drain", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
